// File: rtl/cva6_soc_bus_arbiter_pkg.sv
// SoC peripheral bus types, address map and bus FSM state encoding.
package cva6_wrapper_pkg;

  localparam int unsigned NrSlaves = 4;

  typedef enum logic [1:0] {
    External = 2'd0,
    PLIC     = 2'd1,
    CLINT    = 2'd2,
    Debug    = 2'd3
  } axi_slaves_t;

  typedef enum logic [63:0] {
    DebugBase    = 64'h0000_0000,
    CLINTBase    = 64'h0200_0000,
    PLICBase     = 64'h0C00_0000,
    ExternalBase = 64'h1000_0000
  } soc_bus_start_t;

  localparam logic [63:0] DebugLength    = 64'h0000_1000;
  localparam logic [63:0] CLINTLength    = 64'h000C_0000;
  localparam logic [63:0] PLICLength     = 64'h0400_0000;
  localparam logic [63:0] ExternalLength = 64'h7000_0000;

  // Indexed by axi_slaves_t.
  localparam logic [63:0] Base [NrSlaves] = '{
    64'(ExternalBase), 64'(PLICBase), 64'(CLINTBase), 64'(DebugBase)
  };
  localparam logic [63:0] Length [NrSlaves] = '{
    ExternalLength, PLICLength, CLINTLength, DebugLength
  };

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RSP = 3'd2,
    ERR      = 3'd3,
    RSP      = 3'd4
  } bus_state_e;

  // Subtract-then-compare form avoids overflow at the top of the address space.
  function automatic logic addr_hit(input logic [63:0] addr, input axi_slaves_t idx);
    return (addr >= Base[idx]) && ((addr - Base[idx]) < Length[idx]);
  endfunction

endpackage

// File: rtl/cva6_soc_bus_arbiter_rr_arbiter.sv
// Round-robin grant selection; holds the index of the last granted requester.
module cva6_rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NumReq-1:0] i_req,
  input  logic              i_update,
  output logic              o_gnt_valid,
  output logic [IdxW-1:0]   o_gnt_idx
);

  logic [IdxW-1:0] r_rr_last;
  logic [IdxW-1:0] w_cand;

  // Search from rr_last+1 upward; the descending loop lets the nearest requester win.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_cand      = '0;
    for (int off = int'(NumReq); off >= 1; off--) begin
      w_cand = IdxW'((int'(r_rr_last) + off) % int'(NumReq));
      if (i_req[w_cand]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_cand;
      end
    end
  end

  // Reset to the last requester so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_last <= IdxW'(NumReq - 1);
    end else if (i_update) begin
      r_rr_last <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/cva6_soc_bus_arbiter.sv
// Single-outstanding SoC peripheral bus: arbitrates masters, decodes the
// target by address, forwards the request and routes the response back.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | arbitrate; accept one request, latch it, decode the target
// ISSUE    | request presented to the selected target until it is ready
// WAIT_RSP | waiting for the target response, bounded by the timeout
// ERR      | unmapped address; forms an error response
// RSP      | response presented to the owning master until it is ready
module cva6_soc_bus_arbiter
  import cva6_wrapper_pkg::*;
#(
  parameter int unsigned NumMasters    = 2,
  parameter int unsigned NumTargets    = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumMasters-1:0]                 m_req_valid_i,
  output logic [NumMasters-1:0]                 m_req_ready_o,
  input  logic [NumMasters-1:0][AddrWidth-1:0]  m_req_addr_i,
  input  logic [NumMasters-1:0]                 m_req_we_i,
  input  logic [NumMasters-1:0][DataWidth-1:0]  m_req_wdata_i,
  input  logic [NumMasters-1:0][DataWidth/8-1:0] m_req_be_i,
  output logic [NumMasters-1:0]                 m_rsp_valid_o,
  input  logic [NumMasters-1:0]                 m_rsp_ready_i,
  output logic [DataWidth-1:0]                  m_rsp_rdata_o,
  output logic                                  m_rsp_err_o,
  output logic [NumTargets-1:0]                 t_req_valid_o,
  input  logic [NumTargets-1:0]                 t_req_ready_i,
  output logic [AddrWidth-1:0]                  t_req_addr_o,
  output logic                                  t_req_we_o,
  output logic [DataWidth-1:0]                  t_req_wdata_o,
  output logic [DataWidth/8-1:0]                t_req_be_o,
  input  logic [NumTargets-1:0]                 t_rsp_valid_i,
  input  logic [NumTargets-1:0][DataWidth-1:0]  t_rsp_rdata_i,
  input  logic [NumTargets-1:0]                 t_rsp_err_i
);

  localparam int unsigned MIdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
  localparam int unsigned TIdxW = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int unsigned CntW  = $clog2(TimeoutCycles);

  bus_state_e          r_state;
  logic [MIdxW-1:0]    r_owner;
  logic [TIdxW-1:0]    r_sel;
  logic [AddrWidth-1:0] r_addr;
  logic                r_we;
  logic [DataWidth-1:0] r_wdata;
  logic [DataWidth/8-1:0] r_be;
  logic [DataWidth-1:0] r_rdata;
  logic                r_err;
  logic [CntW-1:0]     r_tmo_cnt;

  logic                w_gnt_valid;
  logic [MIdxW-1:0]    w_gnt_idx;
  logic                w_accept;
  logic [AddrWidth-1:0] w_gnt_addr;
  logic                w_hit_any;
  logic [TIdxW-1:0]    w_hit_idx;

  cva6_rr_arbiter #(
    .NumReq (NumMasters),
    .IdxW   (MIdxW)
  ) u_rr_arbiter (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_req       (m_req_valid_i),
    .i_update    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_accept   = (r_state == IDLE) && w_gnt_valid && !rst_i;
  assign w_gnt_addr = m_req_addr_i[w_gnt_idx];

  // Address decode of the granted request; the lowest matching target wins.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int k = int'(NumTargets) - 1; k >= 0; k--) begin
      if (addr_hit(64'(w_gnt_addr), axi_slaves_t'(k))) begin
        w_hit_any = 1'b1;
        w_hit_idx = TIdxW'(k);
      end
    end
  end

  // Bus FSM, latched request/response fields and timeout down-counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt_idx;
            r_addr  <= w_gnt_addr;
            r_we    <= m_req_we_i[w_gnt_idx];
            r_wdata <= m_req_wdata_i[w_gnt_idx];
            r_be    <= m_req_be_i[w_gnt_idx];
            r_sel   <= w_hit_idx;
            r_state <= w_hit_any ? ISSUE : ERR;
          end
        end
        ISSUE: begin
          if (t_req_ready_i[r_sel]) begin
            r_tmo_cnt <= CntW'(TimeoutCycles - 1);
            r_state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (t_rsp_valid_i[r_sel]) begin
            r_rdata <= t_rsp_rdata_i[r_sel];
            r_err   <= t_rsp_err_i[r_sel];
            r_state <= RSP;
          end else if (r_tmo_cnt == '0) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= RSP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
          end
        end
        ERR: begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= RSP;
        end
        RSP: begin
          if (m_rsp_ready_i[r_owner]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One-hot handshake outputs decoded from the state and latched indices.
  always_comb begin
    m_req_ready_o = '0;
    t_req_valid_o = '0;
    m_rsp_valid_o = '0;
    if (w_accept) begin
      m_req_ready_o[w_gnt_idx] = 1'b1;
    end
    if (r_state == ISSUE) begin
      t_req_valid_o[r_sel] = 1'b1;
    end
    if (r_state == RSP) begin
      m_rsp_valid_o[r_owner] = 1'b1;
    end
  end

  assign t_req_addr_o  = r_addr;
  assign t_req_we_o    = r_we;
  assign t_req_wdata_o = r_wdata;
  assign t_req_be_o    = r_be;
  assign m_rsp_rdata_o = r_rdata;
  assign m_rsp_err_o   = (r_state == RSP) && r_err;

endmodule
